// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port general-purpose register file that sits between
//   the ID stage (read ports) and the WB stage (write ports) of the core.
//   Adds the following to the classic 2R/1W regfile:
//     * same-address write arbitration (the highest port index wins) with a
//       registered conflict pulse,
//     * same-cycle write-to-read bypass,
//     * a sequential clear engine that zeroes one entry per cycle and
//       reports its progress through a registered busy flag.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous reset, active-high (starts a full clear)
//   clear_req    in   one-cycle request to zero the whole array (IDLE only)
//   busy         out  high while the clear engine runs (registered)
//   we           in   [NUM_WR]         per-port write enable
//   waddr        in   [NUM_WR*ADDR_W]  write addresses, port k at [k*ADDR_W +: ADDR_W]
//   wdata        in   [NUM_WR*DATA_W]  write data,      port k at [k*DATA_W +: DATA_W]
//   re           in   [NUM_RD]         per-port read enable
//   raddr        in   [NUM_RD*ADDR_W]  read addresses, packed as waddr
//   rdata        out  [NUM_RD*DATA_W]  read data, combinational
//   wr_conflict  out  registered one-cycle pulse: two enabled write ports hit
//                     the same non-suppressed address on the previous edge
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_req,
  output logic                       busy,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR*ADDR_W-1:0]   waddr,
  input  logic [NUM_WR*DATA_W-1:0]   wdata,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic                       wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_busy;
  logic                r_wr_conflict;
  logic [DATA_W-1:0]   r_regs [DEPTH];

  // The array is open to writes and bypass only when neither reset nor the
  // clear engine owns it.
  logic                w_open;
  logic [NUM_WR-1:0]   w_wr_ok;
  logic                w_conflict;

  assign w_open = !rst && !r_busy;

  // Per-port write qualification: enabled, array open, and not aimed at the
  // hardwired zero entry.
  always_comb begin
    w_wr_ok = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      w_wr_ok[k] = w_open && we[k] &&
                   !((ZERO_REG != 0) && (waddr[k*ADDR_W +: ADDR_W] == '0));
    end
  end

  // Any pair of qualified write ports with equal addresses is a conflict.
  // Suppressed writes (entry 0 with ZERO_REG) never count.
  always_comb begin
    w_conflict = 1'b0;
    for (int a = 0; a < NUM_WR; a++) begin
      for (int b = a + 1; b < NUM_WR; b++) begin
        if (w_wr_ok[a] && w_wr_ok[b] &&
            (waddr[a*ADDR_W +: ADDR_W] == waddr[b*ADDR_W +: ADDR_W])) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  // Clear FSM. rst forces CLEAR from cnt 0, so a reset in the middle of a
  // clear restarts it; clear_req only matters in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_CLEAR;
      r_cnt         <= '0;
      r_busy        <= 1'b1;
      r_wr_conflict <= 1'b0;
    end else begin
      r_wr_conflict <= w_conflict;
      case (r_state)
        S_IDLE: begin
          if (clear_req) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          // Last entry is cleared on this edge; leave together with busy.
          if (&r_cnt) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage. Reset itself never touches the array; the clear engine zeroes
  // one entry per cycle afterwards. Ports are applied in ascending order so
  // the highest-index port wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_regs[r_cnt] <= '0;
      end else begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (w_wr_ok[k]) begin
            r_regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Read ports: gated to zero while the array is closed or the port is idle,
  // entry 0 reads zero when hardwired, otherwise the highest-index matching
  // enabled writer is forwarded ahead of the stored value.
  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;

    assign w_ra = raddr[j*ADDR_W +: ADDR_W];

    always_comb begin
      w_rd = '0;
      if (w_open && re[j] && !((ZERO_REG != 0) && (w_ra == '0))) begin
        w_rd = r_regs[w_ra];
        if (BYPASS != 0) begin
          for (int k = 0; k < NUM_WR; k++) begin
            if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == w_ra)) begin
              w_rd = wdata[k*DATA_W +: DATA_W];
            end
          end
        end
      end
    end

    assign rdata[j*DATA_W +: DATA_W] = w_rd;
  end

  assign busy        = r_busy;
  assign wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//   Two instances share one stimulus stream:
//     inst 0 : ZERO_REG=1, BYPASS=1 (default configuration)
//     inst 1 : ZERO_REG=0, BYPASS=0
//   A behavioural model (plain array per instance plus a remaining-clear
//   cycle count) predicts rdata, busy and wr_conflict.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic        clk;
  logic        rst;
  logic        clear_req;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata0, rdata1;
  logic        busy0, busy1;
  logic        conf0, conf1;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int          clr_left;
  bit          mconf [2];
  logic [31:0] mem   [2][DEPTH];

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2),
               .ZERO_REG(1), .BYPASS(1)) u_dut0 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy0),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata0), .wr_conflict(conf0)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2),
               .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy1),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata1), .wr_conflict(conf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit zr(int inst);
    return inst == 0;
  endfunction

  function automatic bit bp(int inst);
    return inst == 0;
  endfunction

  function automatic logic [31:0] dut_rd(int inst, int j);
    return (inst == 0) ? rdata0[j*32 +: 32] : rdata1[j*32 +: 32];
  endfunction

  function automatic logic dut_busy(int inst);
    return (inst == 0) ? busy0 : busy1;
  endfunction

  function automatic logic dut_conf(int inst);
    return (inst == 0) ? conf0 : conf1;
  endfunction

  // Expected read value from the read-path rules.
  function automatic logic [31:0] exp_rd(int inst, int j);
    logic [4:0] ra;
    ra = raddr[j*5 +: 5];
    if (rst || clr_left > 0 || !re[j]) return 32'h0;
    if (zr(inst) && ra == 5'd0) return 32'h0;
    if (bp(inst))
      for (int k = 1; k >= 0; k--)
        if (we[k] && waddr[k*5 +: 5] == ra) return wdata[k*32 +: 32];
    return mem[inst][ra];
  endfunction

  task automatic zero_model();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < DEPTH; a++) mem[i][a] = 32'h0;
  endtask

  // Advance the model across one rising edge, then the clock itself.
  task automatic step();
    if (rst) begin
      clr_left = DEPTH;
      mconf[0] = 0; mconf[1] = 0;
      zero_model();
    end else if (clr_left > 0) begin
      clr_left--;
      mconf[0] = 0; mconf[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit ok [2];
        for (int k = 0; k < 2; k++) begin
          ok[k] = we[k] && !(zr(i) && waddr[k*5 +: 5] == 5'd0);
          if (ok[k]) mem[i][waddr[k*5 +: 5]] = wdata[k*32 +: 32];
        end
        mconf[i] = ok[0] && ok[1] && (waddr[4:0] == waddr[9:5]);
      end
      if (clear_req) begin
        clr_left = DEPTH;
        zero_model();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(int k, bit en, logic [4:0] a, logic [31:0] d);
    we[k] = en;
    waddr[k*5 +: 5] = a;
    wdata[k*32 +: 32] = d;
  endtask

  task automatic set_r(int j, bit en, logic [4:0] a);
    re[j] = en;
    raddr[j*5 +: 5] = a;
  endtask

  task automatic idle_inputs();
    clear_req = 0;
    we = 0; waddr = 0; wdata = 0;
    re = 0; raddr = 0;
  endtask

  task automatic rand_inputs(bit clr_ok);
    for (int k = 0; k < 2; k++)
      set_w(k, $urandom_range(0, 1),
            ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom),
            $urandom);
    for (int j = 0; j < 2; j++)
      set_r(j, $urandom_range(0, 3) != 0,
            ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom));
    clear_req = clr_ok && ($urandom_range(0, 63) == 0);
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    rst = 1;
    re = 2'b11;
    repeat (3) begin
      step();
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (dut_busy(i) !== 1'b1) begin
          n_fail++; $display("FAIL reset_busy inst%0d: got %b exp 1", i, dut_busy(i));
        end
        n_chk++;
        if (dut_conf(i) !== 1'b0) begin
          n_fail++; $display("FAIL reset_conf inst%0d: got %b exp 0", i, dut_conf(i));
        end
      end
    end
    rst = 0;
    n = 0;
    while (busy0 === 1'b1 && n < 100) begin
      rand_inputs(0);
      #1;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          n_chk++;
          if (dut_rd(i, j) !== 32'h0) begin
            n_fail++; $display("FAIL reset_clear_rd inst%0d p%0d: got %h exp 0", i, j, dut_rd(i, j));
          end
        end
      step();
      n++;
    end
    n_chk++;
    if (n != DEPTH) begin
      n_fail++; $display("FAIL reset_busy_len: got %0d exp %0d", n, DEPTH);
    end
    n_chk++;
    if (busy1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy1_end: got %b exp 0", busy1);
    end
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      set_r(0, 1, 5'(a));
      set_r(1, 1, 5'(DEPTH - 1 - a));
      #1;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          n_chk++;
          if (dut_rd(i, j) !== 32'h0) begin
            n_fail++; $display("FAIL reset_readall inst%0d p%0d a%0d: got %h exp 0", i, j, a, dut_rd(i, j));
          end
        end
      step();
    end
  endtask

  task automatic test_basic();
    idle_inputs();
    set_w(0, 1, 5'd5, 32'hDEADBEEF);
    step();
    idle_inputs();
    set_r(0, 1, 5'd5);
    set_r(1, 1, 5'd0);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (dut_rd(i, 0) !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL basic_rd5 inst%0d: got %h exp deadbeef", i, dut_rd(i, 0));
      end
      n_chk++;
      if (dut_rd(i, 1) !== exp_rd(i, 1)) begin
        n_fail++; $display("FAIL basic_rd0 inst%0d: got %h exp %h", i, dut_rd(i, 1), exp_rd(i, 1));
      end
    end
    n_chk++;
    if (rdata0[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL basic_zero_reg: got %h exp 0", rdata0[63:32]);
    end
    re[0] = 0;
    #1;
    n_chk++;
    if (rdata0[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL basic_re_off: got %h exp 0", rdata0[31:0]);
    end
    step();
  endtask

  task automatic test_bypass();
    idle_inputs();
    set_w(1, 1, 5'd7, 32'h12345678);
    set_r(0, 1, 5'd7);
    set_r(1, 1, 5'd7);
    #1;
    for (int j = 0; j < 2; j++) begin
      n_chk++;
      if (dut_rd(0, j) !== 32'h12345678) begin
        n_fail++; $display("FAIL bypass_on p%0d: got %h exp 12345678", j, dut_rd(0, j));
      end
      n_chk++;
      if (dut_rd(1, j) !== 32'h0) begin
        n_fail++; $display("FAIL bypass_off p%0d: got %h exp 0", j, dut_rd(1, j));
      end
    end
    step();
    we = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (dut_rd(i, 0) !== 32'h12345678) begin
        n_fail++; $display("FAIL bypass_after inst%0d: got %h exp 12345678", i, dut_rd(i, 0));
      end
    end
  endtask

  task automatic test_conflict();
    idle_inputs();
    set_w(0, 1, 5'd3, 32'hAAAA0000);
    set_w(1, 1, 5'd3, 32'h5555FFFF);
    step();
    idle_inputs();
    set_r(0, 1, 5'd3);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (dut_conf(i) !== 1'b1) begin
        n_fail++; $display("FAIL conflict_pulse inst%0d: got %b exp 1", i, dut_conf(i));
      end
      n_chk++;
      if (dut_rd(i, 0) !== 32'h5555FFFF) begin
        n_fail++; $display("FAIL conflict_winner inst%0d: got %h exp 5555ffff", i, dut_rd(i, 0));
      end
    end
    step();
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (dut_conf(i) !== 1'b0) begin
        n_fail++; $display("FAIL conflict_one_cycle inst%0d: got %b exp 0", i, dut_conf(i));
      end
    end
  endtask

  task automatic test_zero();
    idle_inputs();
    set_w(0, 1, 5'd0, 32'hFFFFFFFF);
    set_r(0, 1, 5'd0);
    set_r(1, 1, 5'd0);
    #1;
    for (int j = 0; j < 2; j++) begin
      n_chk++;
      if (dut_rd(0, j) !== 32'h0) begin
        n_fail++; $display("FAIL zero_same_cycle p%0d: got %h exp 0", j, dut_rd(0, j));
      end
      n_chk++;
      if (dut_rd(1, j) !== exp_rd(1, j)) begin
        n_fail++; $display("FAIL zero_plain_same p%0d: got %h exp %h", j, dut_rd(1, j), exp_rd(1, j));
      end
    end
    step();
    we = 0;
    #1;
    n_chk++;
    if (rdata0[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL zero_next: got %h exp 0", rdata0[31:0]);
    end
    n_chk++;
    if (rdata1[31:0] !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL zero_plain_next: got %h exp ffffffff", rdata1[31:0]);
    end
    set_w(0, 1, 5'd0, 32'h0BAD0001);
    set_w(1, 1, 5'd0, 32'h600D0002);
    step();
    we = 0;
    #1;
    n_chk++;
    if (conf0 !== 1'b0) begin
      n_fail++; $display("FAIL zero_no_conflict: got %b exp 0", conf0);
    end
    n_chk++;
    if (conf1 !== 1'b1) begin
      n_fail++; $display("FAIL zero_plain_conflict: got %b exp 1", conf1);
    end
    n_chk++;
    if (rdata1[31:0] !== 32'h600D0002) begin
      n_fail++; $display("FAIL zero_plain_winner: got %h exp 600d0002", rdata1[31:0]);
    end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      rand_inputs(1);
      #1;
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (dut_busy(i) !== (clr_left > 0)) begin
          n_fail++; $display("FAIL rand_busy inst%0d c%0d: got %b exp %b", i, c, dut_busy(i), clr_left > 0);
        end
        n_chk++;
        if (dut_conf(i) !== mconf[i]) begin
          n_fail++; $display("FAIL rand_conf inst%0d c%0d: got %b exp %b", i, c, dut_conf(i), mconf[i]);
        end
        for (int j = 0; j < 2; j++) begin
          n_chk++;
          if (dut_rd(i, j) !== exp_rd(i, j)) begin
            n_fail++; $display("FAIL rand_rd inst%0d p%0d c%0d: got %h exp %h", i, j, c, dut_rd(i, j), exp_rd(i, j));
          end
        end
      end
      step();
    end
    rst = 0;
    idle_inputs();
    for (int c = 0; c < 40 && clr_left > 0; c++) step();
  endtask

  task automatic fill_regs();
    idle_inputs();
    for (int a = 1; a < DEPTH; a += 2) begin
      set_w(0, 1, 5'(a), $urandom);
      set_w(1, (a + 1) < DEPTH, 5'((a + 1) % DEPTH), $urandom);
      step();
    end
    idle_inputs();
  endtask

  task automatic test_midclear();
    int n;
    // Clear with writes during busy and an ignored second request.
    fill_regs();
    clear_req = 1;
    step();
    clear_req = 0;
    n = 0;
    while (busy0 === 1'b1 && n < 100) begin
      rand_inputs(0);
      clear_req = (n == 10);
      #1;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          n_chk++;
          if (dut_rd(i, j) !== exp_rd(i, j)) begin
            n_fail++; $display("FAIL midclear_rd inst%0d p%0d n%0d: got %h exp %h", i, j, n, dut_rd(i, j), exp_rd(i, j));
          end
        end
      step();
      n++;
    end
    n_chk++;
    if (n != DEPTH) begin
      n_fail++; $display("FAIL midclear_busy_len: got %0d exp %0d", n, DEPTH);
    end
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      set_r(0, 1, 5'(a));
      #1;
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (dut_rd(i, 0) !== 32'h0) begin
          n_fail++; $display("FAIL midclear_readall inst%0d a%0d: got %h exp 0", i, a, dut_rd(i, 0));
        end
      end
      step();
    end
    // Reset in the middle of a clear restarts it.
    fill_regs();
    clear_req = 1;
    step();
    clear_req = 0;
    for (int c = 0; c < 20; c++) begin
      rand_inputs(0);
      step();
    end
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
    n = 0;
    while (busy0 === 1'b1 && n < 100) begin
      step();
      n++;
    end
    n_chk++;
    if (n != DEPTH) begin
      n_fail++; $display("FAIL rstclear_busy_len: got %0d exp %0d", n, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) begin
      set_r(1, 1, 5'(a));
      #1;
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (dut_rd(i, 1) !== 32'h0) begin
          n_fail++; $display("FAIL rstclear_readall inst%0d a%0d: got %h exp 0", i, a, dut_rd(i, 1));
        end
      end
      step();
    end
  endtask

  initial begin
    rst = 1;
    clr_left = DEPTH;
    mconf[0] = 0; mconf[1] = 0;
    zero_model();
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_bypass();
    test_conflict();
    test_zero();
    test_midclear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
